// File: rtl/alu_mc.sv
// alu_mc: multi-cycle handshaked Y86-64 execute ALU with registered result and CC.
// Define ALU_MUL_EN for iterative MUL on alufun 7; otherwise alufun 7 is SAR.
module alu_mc #(
   parameter int WIDTH = 64,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alufun,
   input  logic [WIDTH-1:0] alua,
   input  logic [WIDTH-1:0] alub,
   input  logic             set_cc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] vale,
   output logic             out_err,
   output logic [2:0]       cc,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
`ifdef ALU_MUL_EN
      S_MUL  = 2'd2,
`endif
      S_DONE = 2'd1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] vale_q, vale_d;
   logic             err_q, err_d;
   logic [2:0]       cc_q, cc_d;

`ifdef ALU_MUL_EN
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [SHW:0]     cnt_q, cnt_d;
   logic             scc_q, scc_d;
`endif

   logic [SHW-1:0]   sh;
   logic [WIDTH-1:0] res;
   logic             of;
   logic             err;
   logic             accept;

   assign in_ready  = (state_q == S_IDLE) ||
                      ((state_q == S_DONE) && out_ready);
   assign out_valid = (state_q == S_DONE);
   assign vale      = vale_q;
   assign out_err   = err_q;
   assign cc        = cc_q;
   assign accept    = in_valid && in_ready;

`ifdef ALU_MUL_EN
   assign busy = (state_q == S_MUL);
`else
   assign busy = 1'b0;
`endif

   always_comb begin
      sh  = alua[SHW-1:0];
      res = '0;
      of  = 1'b0;
      err = 1'b0;
      unique case (alufun)
         3'd0: begin
            res = alub + alua;
            of  = (alua[WIDTH-1] == alub[WIDTH-1]) &&
                  (res[WIDTH-1] != alua[WIDTH-1]);
         end
         3'd1: begin
            res = alub - alua;
            of  = (alua[WIDTH-1] != alub[WIDTH-1]) &&
                  (res[WIDTH-1] != alub[WIDTH-1]);
         end
         3'd2: res = alub & alua;
         3'd3: res = alub ^ alua;
         3'd4: res = alub | alua;
         3'd5: res = alub << sh;
         3'd6: res = alub >> sh;
`ifdef ALU_MUL_EN
         3'd7: res = '0;
`else
         3'd7: res = WIDTH'($signed(alub) >>> sh);
`endif
      endcase
   end

   always_comb begin
      state_d = state_q;
      vale_d  = vale_q;
      err_d   = err_q;
      cc_d    = cc_q;
`ifdef ALU_MUL_EN
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      scc_d = scc_q;
`endif
      if ((state_q == S_DONE) && out_ready)
         state_d = S_IDLE;
`ifdef ALU_MUL_EN
      // Final count is a write-back cycle for the finished product.
      if (state_q == S_MUL) begin
         if (cnt_q == (SHW+1)'(WIDTH)) begin
            vale_d  = acc_q;
            err_d   = 1'b0;
            state_d = S_DONE;
            if (scc_q)
               cc_d = {acc_q == '0, acc_q[WIDTH-1], 1'b0};
         end else begin
            if (a_q[0])
               acc_d = acc_q + b_q;
            a_d   = a_q >> 1;
            b_d   = b_q << 1;
            cnt_d = cnt_q + (SHW+1)'(1);
         end
      end
`endif
      if (accept) begin
`ifdef ALU_MUL_EN
         if (alufun == 3'd7) begin
            a_d     = alua;
            b_d     = alub;
            acc_d   = '0;
            cnt_d   = '0;
            scc_d   = set_cc;
            state_d = S_MUL;
         end else begin
`else
         begin
`endif
            vale_d  = res;
            err_d   = err;
            state_d = S_DONE;
            if (set_cc && !err)
               cc_d = {res == '0, res[WIDTH-1], of};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         vale_q  <= '0;
         err_q   <= 1'b0;
         cc_q    <= 3'b100;
`ifdef ALU_MUL_EN
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         scc_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         vale_q  <= vale_d;
         err_q   <= err_d;
         cc_q    <= cc_d;
`ifdef ALU_MUL_EN
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         scc_q   <= scc_d;
`endif
      end
   end

endmodule
